add_sub_sequencer: RTL and testbench
====================================

// Module: add_sub_sequencer
// PURPOSE
//   Multi-cycle controller that runs wide add/subtract operations through one shared 4-bit
//   add/sub slice, one nibble per cycle, chaining carry between nibbles.
//   Subtraction is A + ~B + 1 (two's complement: B XOR op, carry-in = op on the first nibble).
//   Accepts requests on a valid/ready handshake and holds results until the consumer accepts them.
// PARAMETERS
//   WORDS    4   number of 4-bit nibbles per operand; operand width W = 4*WORDS (WORDS >= 1)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   request present on op/a/b
//   in_ready   out  1   block can accept a request (IDLE state only)
//   op         in   1   0 = add (a+b), 1 = subtract (a-b)
//   a          in   W   operand A, two's complement / unsigned
//   b          in   W   operand B
//   out_valid  out  1   result/carry_out/overflow are valid
//   out_ready  in   1   consumer accepts the result
//   result     out  W   a+b or a-b, modulo 2^W
//   carry_out  out  1   carry out of the MSB nibble (for sub: 1 = no borrow)
//   overflow   out  1   signed overflow of the W-bit operation
//   busy       out  1   high in RUN or DONE
// BEHAVIOUR
//   - Reset (rst high, any state, any time): state=IDLE, result=0, carry_out=0, overflow=0,
//     out_valid=0, busy=0, nibble index=0; in_ready=0 while rst high, 1 once released.
//     Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
//   - FSM states IDLE, RUN, DONE; any illegal encoding returns to IDLE.
//   - IDLE: in_ready=1. On in_valid&&in_ready: latch a, b, op; carry<=op; idx<=0; -> RUN.
//   - RUN: each cycle nibble idx: {c,s} = a[idx] + (b[idx] ^ {4{op}}) + carry;
//     result[idx]<=s; carry<=c; idx<=idx+1. When idx==WORDS-1: carry_out<=c;
//     overflow<=(a_msb == b'_msb) && (s_msb != a_msb), b' = b XOR op; -> DONE.
//     in_ready=0; in_valid ignored.
//   - DONE: out_valid=1; result, carry_out, overflow held stable. On out_ready -> IDLE next
//     cycle, out_valid deasserts. Waits indefinitely with out_ready low.
//   - Latency: acceptance edge + WORDS RUN edges; out_valid high on the WORDS-th edge after
//     acceptance. Throughput: one op per WORDS+2 cycles minimum (no IDLE/DONE overlap).
//   - Inputs a/b/op may change after acceptance without effect (latched copies are used).
//   - idx width = clog2(WORDS) (min 1); idx never exceeds WORDS-1. WORDS=1 -> single RUN cycle.
//   - result holds its last value in IDLE; it is only meaningful when out_valid=1.
// STRUCTURE
//   - Shared package add_sub_pkg: SLICE_W=4, OP_ADD=1'b0, OP_SUB=1'b1,
//     state encodings ST_IDLE/ST_RUN/ST_DONE.
//   - One sub-module: add_sub_slice (combinational 4-bit slice: inputs x, y, op, cin;
//     outputs s, cout; y inverted when op=1). The sequencer instantiates exactly one
//     and muxes nibbles into it by idx.
//   - All sequencing, latching and flags live in add_sub_sequencer.
// TESTING (WORDS=4 unless noted)
//   1 add: a=16'h1234, b=16'h0FED, op=0 -> result=16'h2221, carry_out=0, overflow=0,
//     out_valid exactly 4 cycles after acceptance edge.
//   2 sub borrow: a=16'h0000, b=16'h0001, op=1 -> result=16'hFFFF, carry_out=0, overflow=0.
//     sub no borrow: a=16'h0005, b=16'h0003 -> 16'h0002, carry_out=1.
//   3 overflow: a=16'h7FFF+b=16'h0001 -> 16'h8000, ovf=1; a=16'h8000-b=16'h0001 ->
//     16'h7FFF, ovf=1, carry_out=1; a=16'hFFFF+b=16'h0001 -> 16'h0000, carry_out=1, ovf=0.
//   4 backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new
//     operands -> out_valid and result stable, in_ready=0, second request not taken until
//     IDLE; then it completes correctly.
//   5 reset mid-op: assert rst during 2nd RUN cycle -> all outputs 0 immediately
//     (async), in_ready=1 after release; next op 16'h0003+16'h0004 -> 16'h0007.
//   6 exhaustive WORDS=1: all 16x16x2 a/b/op combos vs. reference model ((a +/- b) mod 16,
//     carry, signed overflow), back-to-back with out_ready=1.

Source files
------------

// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared constants and state encoding for the nibble-serial add/sub sequencer
package add_sub_pkg;

    localparam int   SLICE_W = 4;
    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_sub_sequencer_if.sv
// rtl/add_sub_sequencer_if.sv - request/response bundle between a requester (master) and the sequencer (slave)
//   in_valid/in_ready/op/a/b : request handshake and operands
//   out_valid/out_ready      : response handshake
//   result/carry_out/overflow: response payload, busy: operation in flight
interface add_sub_sequencer_if #(
    parameter int WORDS = 4
);
    import add_sub_pkg::*;

    localparam int W = SLICE_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, busy
    );

endinterface

// File: rtl/add_sub_slice.sv
// rtl/add_sub_slice.sv - combinational 4-bit add/sub slice, y inverted when op selects subtract
//   x, y : nibble operands        op  : 0 add, 1 subtract (invert y)
//   cin  : carry in               s   : nibble sum, cout : carry out
module add_sub_slice
    import add_sub_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               op,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W-1:0] y_eff;
    logic [SLICE_W:0]   sum;

    always_comb begin
        y_eff = y ^ {SLICE_W{op != OP_ADD}};
        sum   = {1'b0, x} + {1'b0, y_eff} + {{SLICE_W{1'b0}}, cin};
    end

    assign s    = sum[SLICE_W-1:0];
    assign cout = sum[SLICE_W];

endmodule

// File: rtl/add_sub_sequencer.sv
// rtl/add_sub_sequencer.sv - wide add/subtract run one nibble per cycle through a single shared slice
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of add_sub_sequencer_if (request in, held response out)
module add_sub_sequencer
    import add_sub_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    add_sub_sequencer_if.slave  bus
);

    localparam int                W        = SLICE_W * WORDS;
    localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORDS - 1);

    state_t           state_q,     state_d;
    logic [W-1:0]     a_q,         a_d;
    logic [W-1:0]     b_q,         b_d;
    logic             op_q,        op_d;
    logic             carry_q,     carry_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [W-1:0]     result_q,    result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q,  overflow_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic [SLICE_W-1:0] slice_x;
    logic [SLICE_W-1:0] slice_y;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;

    // The one shared slice sees the nibble selected by idx from the latched operands.
    assign slice_x = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
    assign slice_y = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

    add_sub_slice u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .op   (op_q),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    // Subtract is a + ~b + 1: the +1 enters as the first nibble's carry.
                    carry_d = (bus.op == OP_SUB);
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                result_d[int'(idx_q) * SLICE_W +: SLICE_W] = slice_s;
                carry_d = slice_cout;
                if (idx_q == IDX_LAST) begin
                    carry_out_d = slice_cout;
                    // Signed overflow: operands (after b inversion) agree in sign, sum does not.
                    overflow_d  = (a_q[W-1] == (b_q[W-1] ^ op_q)) &&
                                  (slice_s[SLICE_W-1] != a_q[W-1]);
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                idx_d       = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // in_ready drops with rst directly so no request is taken while reset is held.
    assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_add_sub_sequencer.sv
// tb/tb_add_sub_sequencer.sv - self-checking bench: WORDS=4 vectors and corner sequences, exhaustive WORDS=1
module tb_add_sub_sequencer;
    import add_sub_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_sub_sequencer_if #(.WORDS(4)) bus4 ();
    add_sub_sequencer_if #(.WORDS(1)) bus1 ();

    add_sub_sequencer #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    add_sub_sequencer #(.WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        v;
    } exp_t;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        v;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q4[$];
    logic [5:0] q1[$];
    exp_t mon4_e;
    logic [5:0] mon1_e;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboards: pop expected results when a response handshake is seen.
    always @(negedge clk) begin
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result4 actual=%h required=none", bus4.result);
            end else begin
                mon4_e = q4.pop_front();
                check("result4",    32'(bus4.result),    32'(mon4_e.res));
                check("carry_out4", 32'(bus4.carry_out), 32'(mon4_e.c));
                check("overflow4",  32'(bus4.overflow),  32'(mon4_e.v));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result1 actual=%h required=none", bus1.result);
            end else begin
                mon1_e = q1.pop_front();
                check("exh1_res_c_v", 32'({bus1.result, bus1.carry_out, bus1.overflow}), 32'(mon1_e));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the acceptance edge.
    task automatic issue4(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input logic c, input logic v);
        bit got;
        got = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.op = op;
        bus4.a  = a;
        bus4.b  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus4.in_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept4_timeout actual=no_accept required=accept");
            bus4.in_valid = 1'b0;
        end else begin
            q4.push_back('{res: res, c: c, v: v});
            @(posedge clk);
            #1;
            bus4.in_valid = 1'b0;
            bus4.op = ~op;
            bus4.a  = ~a;
            bus4.b  = ~b;
        end
    endtask

    task automatic drain4();
        int i;
        i = 0;
        while ((q4.size() != 0 || bus4.out_valid) && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (i >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain4_timeout actual=pending required=empty");
        end
    endtask

    task automatic issue1(input logic op, input logic [3:0] a, input logic [3:0] b,
                          input logic [5:0] e);
        bit got;
        got = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.op = op;
        bus1.a  = a;
        bus1.b  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus1.in_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept1_timeout actual=no_accept required=accept");
            bus1.in_valid = 1'b0;
        end else begin
            q1.push_back(e);
            @(posedge clk);
            #1;
            bus1.in_valid = 1'b0;
        end
    endtask

    // Reference for a 4-bit op from integer arithmetic, not from nibble chaining.
    function automatic logic [5:0] ref1(input logic op, input int a, input int b);
        int sa, sb, sr, raw;
        logic c, v;
        logic [3:0] r;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        if (op == OP_ADD) begin
            raw = a + b;
            c   = (raw > 15);
            sr  = sa + sb;
        end else begin
            raw = a - b;
            c   = (a >= b);
            sr  = sa - sb;
        end
        r = 4'((raw + 16) % 16);
        v = (sr > 7) || (sr < -8);
        return {r, c, v};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        tbl[0] = '{OP_ADD, 16'h1234, 16'h0FED, 16'h2221, 1'b0, 1'b0};
        tbl[1] = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        tbl[2] = '{OP_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0};
        tbl[3] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{OP_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        tbl[8] = '{OP_SUB, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1};

        bus4.in_valid = 1'b0; bus4.op = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.op = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
        rst = 1'b0;
        #1;
        rst = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(bus4.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_busy",      32'(bus4.busy),      32'd0);
        check("rst_result",    32'(bus4.result),    32'd0);
        check("rst_carry_out", 32'(bus4.carry_out), 32'd0);
        check("rst_overflow",  32'(bus4.overflow),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus4.in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            issue4(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].c, tbl[i].v);
            check("run_busy",     32'(bus4.busy),     32'd1);
            check("run_in_ready", 32'(bus4.in_ready), 32'd0);
            n = 0;
            while (!bus4.out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("latency", 32'(n), 32'd4);
            drain4();
        end

        // Backpressure: a second request waits while the first result is held.
        bus4.out_ready = 1'b0;
        issue4(OP_ADD, 16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0);
        n = 0;
        while (!bus4.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus4.in_valid = 1'b1;
        bus4.op = OP_SUB;
        bus4.a  = 16'h0100;
        bus4.b  = 16'h0001;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus4.out_valid), 32'd1);
            check("bp_result",    32'(bus4.result),    32'h5432);
            check("bp_in_ready",  32'(bus4.in_ready),  32'd0);
            check("bp_busy",      32'(bus4.busy),      32'd1);
        end
        @(posedge clk);
        #1;
        bus4.out_ready = 1'b1;
        issue4(OP_SUB, 16'h0100, 16'h0001, 16'h00FF, 1'b1, 1'b0);
        drain4();

        // Reset during the second RUN cycle aborts the operation.
        issue4(OP_ADD, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("mid_rst_busy",      32'(bus4.busy),      32'd0);
        check("mid_rst_result",    32'(bus4.result),    32'd0);
        check("mid_rst_carry_out", 32'(bus4.carry_out), 32'd0);
        check("mid_rst_overflow",  32'(bus4.overflow),  32'd0);
        check("mid_rst_in_ready",  32'(bus4.in_ready),  32'd0);
        q4.delete();
        q1.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready",  32'(bus4.in_ready),  32'd1);
        check("rel_out_valid", 32'(bus4.out_valid), 32'd0);
        @(posedge clk);
        #1;
        issue4(OP_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);
        drain4();

        // Exhaustive WORDS=1, back to back with out_ready held high.
        for (int op = 0; op < 2; op++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    issue1(1'(op), 4'(a), 4'(b), ref1(1'(op), a, b));
                end
            end
        end
        n = 0;
        while ((q1.size() != 0 || bus1.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain1_timeout actual=pending required=empty");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
